// File: rtl/adcscan_bcd.sv
// Scanning ADC sequencer: configures ad2adc, acquires samples, converts each to BCD serially
// and keeps a per-channel digit bank for the LCD side. Optional averaging under ADCAVG_EN.
module adcscan_bcd #(
  parameter int          ADC_W   = 12,
  parameter int          NCH     = 4,
  parameter int          CH_W    = 2,
  parameter int          NDIG    = 4,
  parameter int          DSEL_W  = 2,
  parameter logic [3:0]  CONF_LO = 4'b0000
) (
  input  logic              genclk,
  input  logic              reset,
  input  logic              enable,
  input  logic [NCH-1:0]    chmask,
  output logic              adccf,
  input  logic              cfadc,
  output logic              adcdav,
  input  logic              davadc,
  input  logic [ADC_W-1:0]  adcdata,
  input  logic [CH_W-1:0]   adch,
  output logic [7:0]        adcconf,
  input  logic [CH_W-1:0]   chsel,
  input  logic [DSEL_W-1:0] digitmux,
  output logic [3:0]        data,
  output logic              convdone,
  output logic [CH_W-1:0]   convch,
  output logic [NCH-1:0]    chvalid
);

  localparam int         BW    = 4 * NDIG;
  localparam int         CNT_W = $clog2(ADC_W);
  localparam logic [63:0] MAXV = 64'(10**NDIG - 1);

  typedef enum logic [2:0] {S_CONF, S_IDLE, S_ACQ, S_BCD, S_STORE} state_t;

  state_t                         state_q, state_d;
  logic                           adccf_q, adccf_d;
  logic                           adcdav_q, adcdav_d;
  logic [7:0]                     adcconf_q, adcconf_d;
  logic                           convdone_q, convdone_d;
  logic [CH_W-1:0]                convch_q, convch_d;
  logic [NCH-1:0]                 chvalid_q, chvalid_d;
  logic [NCH-1:0]                 mask_q, mask_d;
  logic [NCH-1:0][NDIG-1:0][3:0]  bank_q, bank_d;
  logic [CH_W-1:0]                ch_q, ch_d;
  logic [ADC_W-1:0]               val_q, val_d;
  logic [ADC_W-1:0]               bin_q, bin_d;
  logic [BW-1:0]                  bcd_q, bcd_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
`ifdef ADCAVG_EN
  logic [NCH-1:0][ADC_W+1:0]      acc_q, acc_d;
  logic [NCH-1:0][1:0]            scnt_q, scnt_d;
  logic [ADC_W+1:0]               sum;
`endif

  logic [3:0]       mask4;
  logic             ch_ok;
  logic [BW-1:0]    adj;
  logic             conv_go;
  logic [ADC_W-1:0] conv_v;
  logic             ovf;

  always_comb begin
    state_d    = state_q;
    adccf_d    = adccf_q;
    adcdav_d   = adcdav_q;
    adcconf_d  = adcconf_q;
    convdone_d = 1'b0;
    convch_d   = convch_q;
    chvalid_d  = chvalid_q;
    mask_d     = mask_q;
    bank_d     = bank_q;
    ch_d       = ch_q;
    val_d      = val_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
`ifdef ADCAVG_EN
    acc_d      = acc_q;
    scnt_d     = scnt_q;
    sum        = '0;
`endif
    conv_go = 1'b0;
    conv_v  = adcdata;
    mask4   = '0;
    mask4[NCH-1:0] = chmask;
    ch_ok   = 1'b0;
    for (int i = 0; i < NCH; i++)
      if (adch == CH_W'(i) && mask_q[i]) ch_ok = 1'b1;
    // Shift-add-3 correction: any digit >= 5 gets +3 before the next shift.
    for (int d = 0; d < NDIG; d++)
      adj[4*d +: 4] = (bcd_q[4*d +: 4] >= 4'd5) ? bcd_q[4*d +: 4] + 4'd3 : bcd_q[4*d +: 4];
    ovf = 64'(val_q) > MAXV;

    case (state_q)
      S_CONF: begin
        if (!adccf_q) begin
          adccf_d   = 1'b1;
          adcconf_d = {mask4, CONF_LO};
          mask_d    = chmask;
`ifdef ADCAVG_EN
          acc_d     = '0;
          scnt_d    = '0;
`endif
        end else if (cfadc) begin
          adccf_d = 1'b0;
          state_d = enable ? S_ACQ : S_IDLE;
        end
      end
      S_IDLE: begin
        if (enable) state_d = (chmask != mask_q) ? S_CONF : S_ACQ;
      end
      S_ACQ: begin
        if (!adcdav_q) begin
          adcdav_d = 1'b1;
        end else if (davadc) begin
          adcdav_d = 1'b0;
          ch_d     = adch;
          state_d  = enable ? S_ACQ : S_IDLE;
          if (ch_ok) begin
`ifdef ADCAVG_EN
            for (int i = 0; i < NCH; i++)
              if (adch == CH_W'(i)) begin
                sum = acc_q[i] + (ADC_W+2)'(adcdata);
                if (scnt_q[i] == 2'd3) begin
                  conv_go = 1'b1;
                  conv_v  = sum[ADC_W+1:2];
                end else begin
                  acc_d[i]  = sum;
                  scnt_d[i] = scnt_q[i] + 2'd1;
                end
              end
`else
            conv_go = 1'b1;
`endif
          end
          if (conv_go) begin
            val_d   = conv_v;
            bin_d   = conv_v;
            bcd_d   = '0;
            cnt_d   = '0;
            state_d = S_BCD;
          end
        end
      end
      S_BCD: begin
        bcd_d = {adj[BW-2:0], bin_q[ADC_W-1]};
        bin_d = bin_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(ADC_W-1)) state_d = S_STORE;
      end
      S_STORE: begin
        for (int i = 0; i < NCH; i++)
          if (ch_q == CH_W'(i)) begin
            bank_d[i]    = ovf ? {NDIG{4'h9}} : bcd_q;
            chvalid_d[i] = 1'b1;
`ifdef ADCAVG_EN
            acc_d[i]     = '0;
            scnt_d[i]    = '0;
`endif
          end
        convch_d   = ch_q;
        convdone_d = 1'b1;
        if (chmask != mask_q) state_d = S_CONF;
        else                  state_d = enable ? S_ACQ : S_IDLE;
      end
      default: state_d = S_CONF;
    endcase
  end

  always_ff @(posedge genclk) begin
    if (reset) begin
      state_q    <= S_CONF;
      adccf_q    <= 1'b0;
      adcdav_q   <= 1'b0;
      adcconf_q  <= '0;
      convdone_q <= 1'b0;
      convch_q   <= '0;
      chvalid_q  <= '0;
      mask_q     <= '0;
      bank_q     <= '0;
      ch_q       <= '0;
      val_q      <= '0;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
`ifdef ADCAVG_EN
      acc_q      <= '0;
      scnt_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      adccf_q    <= adccf_d;
      adcdav_q   <= adcdav_d;
      adcconf_q  <= adcconf_d;
      convdone_q <= convdone_d;
      convch_q   <= convch_d;
      chvalid_q  <= chvalid_d;
      mask_q     <= mask_d;
      bank_q     <= bank_d;
      ch_q       <= ch_d;
      val_q      <= val_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
`ifdef ADCAVG_EN
      acc_q      <= acc_d;
      scnt_q     <= scnt_d;
`endif
    end
  end

  // Display read is a plain mux of the registered bank; out-of-range selects read zero.
  always_comb begin
    data = 4'h0;
    for (int i = 0; i < NCH; i++)
      for (int j = 0; j < NDIG; j++)
        if (chsel == CH_W'(i) && digitmux == DSEL_W'(j)) data = bank_q[i][j];
  end

  assign adccf    = adccf_q;
  assign adcdav   = adcdav_q;
  assign adcconf  = adcconf_q;
  assign convdone = convdone_q;
  assign convch   = convch_q;
  assign chvalid  = chvalid_q;

endmodule

// File: tb/tb_adcscan_bcd.sv
// Bench for adcscan_bcd: ADC-side responder plus an arithmetic model of the digit bank.
module tb_adcscan_bcd;
  localparam int ADC_W = 12, NCH = 4, CH_W = 2, NDIG = 4, DSEL_W = 2;
`ifdef ADCAVG_EN
  localparam int NAVG = 4;
`else
  localparam int NAVG = 1;
`endif

  logic              genclk = 1'b0, reset = 1'b1, enable = 1'b0;
  logic [NCH-1:0]    chmask = '0;
  logic              adccf, adcdav, convdone;
  logic              cfadc = 1'b0, davadc = 1'b0;
  logic [ADC_W-1:0]  adcdata = '0;
  logic [CH_W-1:0]   adch = '0, chsel = '0, convch;
  logic [DSEL_W-1:0] digitmux = '0;
  logic [7:0]        adcconf;
  logic [3:0]        data;
  logic [NCH-1:0]    chvalid;

  adcscan_bcd #(.ADC_W(ADC_W), .NCH(NCH), .CH_W(CH_W), .NDIG(NDIG), .DSEL_W(DSEL_W),
                .CONF_LO(4'b0000)) dut (
    .genclk(genclk), .reset(reset), .enable(enable), .chmask(chmask),
    .adccf(adccf), .cfadc(cfadc), .adcdav(adcdav), .davadc(davadc),
    .adcdata(adcdata), .adch(adch), .adcconf(adcconf), .chsel(chsel),
    .digitmux(digitmux), .data(data), .convdone(convdone), .convch(convch),
    .chvalid(chvalid));

  always #5 genclk = ~genclk;

  int checks = 0, errors = 0;
  int cyc = 0;
  logic [NCH-1:0] mask_at_edge = '0;
  always @(posedge genclk) cyc <= cyc + 1;
  always @(posedge genclk) mask_at_edge <= chmask;

  typedef struct {int due; int ch; int val;} ev_t;
  typedef struct {int d; int ch;} smp_t;
  ev_t  evq[$];
  smp_t fq[$];
  ev_t  ev;
  smp_t rs;
  int   mbank[NCH][NDIG];
  logic [NCH-1:0] mvalid = '0, cfg_mask = '0, cfg_pend = '0;
  int   mconvch = 0;
  int   macc[NCH], mcnt[NCH];
  bit   rand_mode = 0, exp_cd;
  int   cf_wait = 0, cf_target = 3, dav_wait = 0, dav_target = 1;
  int   cap_cyc = 0, dut_cd = 0;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  function automatic int digit_of(int v, int k);
    if (v > 10**NDIG - 1) return 9;
    return (v / 10**k) % 10;
  endfunction

  function automatic int exp_data(int cs, int dm);
    if (cs >= NCH || dm >= NDIG) return 0;
    return mbank[cs][dm];
  endfunction

  // Responder for the ad2adc side and per-cycle comparison against the model.
  always @(negedge genclk) begin
    if (reset) begin
      evq.delete();
      for (int i = 0; i < NCH; i++) begin
        macc[i] = 0; mcnt[i] = 0;
        for (int k = 0; k < NDIG; k++) mbank[i][k] = 0;
      end
      mvalid = '0; mconvch = 0; cfg_mask = '0;
      cfadc = 1'b0; davadc = 1'b0; cf_wait = 0; dav_wait = 0;
    end else begin
      exp_cd = (evq.size() > 0) && (evq[0].due == cyc);
      if (exp_cd) begin
        ev = evq.pop_front();
        for (int k = 0; k < NDIG; k++) mbank[ev.ch][k] = digit_of(ev.val, k);
        mvalid[ev.ch] = 1'b1;
        mconvch = ev.ch;
      end
      chk("convdone", convdone, exp_cd);
      if (convdone) dut_cd++;
      chk("convch", convch, mconvch);
      chk("chvalid", chvalid, mvalid);
      chk("data", data, exp_data(chsel, digitmux));
      digitmux = DSEL_W'(cyc % NDIG);
      chsel    = CH_W'((cyc / NDIG) % NCH);

      if (cfadc) cfadc = 1'b0;
      else if (adccf) begin
        if (cf_wait == 0) begin
          cfg_pend  = mask_at_edge;
          cf_target = rand_mode ? int'($urandom_range(1, 4)) : 3;
        end
        cf_wait++;
        if (cf_wait >= cf_target) begin
          chk("adcconf", adcconf, {cfg_pend, 4'h0});
          cfg_mask = cfg_pend;
          for (int i = 0; i < NCH; i++) begin macc[i] = 0; mcnt[i] = 0; end
          cfadc = 1'b1; cf_wait = 0;
        end
      end

      if (davadc) davadc = 1'b0;
      else if (adcdav && (rand_mode || fq.size() > 0)) begin
        if (dav_wait == 0) dav_target = rand_mode ? int'($urandom_range(1, 3)) : 1;
        dav_wait++;
        if (dav_wait >= dav_target) begin
          dav_wait = 0;
          if (fq.size() > 0) rs = fq.pop_front();
          else begin
            case ($urandom_range(0, 5))
              0: rs.d = 0;
              1: rs.d = 4095;
              2: rs.d = 999 + int'($urandom_range(0, 1));
              default: rs.d = int'($urandom_range(0, 4095));
            endcase
            rs.ch = int'($urandom_range(0, 3));
          end
          adcdata = ADC_W'(rs.d); adch = CH_W'(rs.ch); davadc = 1'b1;
          cap_cyc = cyc + 1;
          if (rs.ch < NCH && cfg_mask[rs.ch]) begin
            if (NAVG == 1) evq.push_back('{cyc + 14, rs.ch, rs.d});
            else begin
              macc[rs.ch] += rs.d; mcnt[rs.ch]++;
              if (mcnt[rs.ch] == NAVG) begin
                evq.push_back('{cyc + 14, rs.ch, macc[rs.ch] / NAVG});
                macc[rs.ch] = 0; mcnt[rs.ch] = 0;
              end
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge genclk); #1;
  endtask

  task automatic push(input int d, input int ch);
    for (int i = 0; i < NAVG; i++) fq.push_back('{d, ch});
  endtask

  task automatic wait_cd(input string n);
    bit got = 0;
    for (int i = 0; i < 200 && !got; i++) begin tick(); if (convdone) got = 1; end
    chk(n, got, 1);
  endtask

  task automatic wait_cf_fall(input string n);
    bit seen = 0, ok = 0;
    for (int i = 0; i < 80 && !ok; i++) begin
      tick();
      if (adccf) seen = 1; else if (seen) ok = 1;
    end
    chk(n, ok, 1);
  endtask

  int e2[NDIG] = '{5, 9, 0, 4};
  int hi, cd0, bad;
  bit got;

  initial begin
    // 1: reset state and first configuration
    enable = 1'b1; chmask = 4'b0001;
    repeat (3) tick();
    chk("rst_adccf", adccf, 0); chk("rst_adcdav", adcdav, 0); chk("rst_adcconf", adcconf, 0);
    chk("rst_convdone", convdone, 0); chk("rst_convch", convch, 0); chk("rst_chvalid", chvalid, 0);
    reset = 1'b0;
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (adccf) hi++; else if (hi > 0) break;
    end
    chk("t1_adccf_cycles", hi, 3);
    chk("t1_adcconf", adcconf, 8'h10);

    // 2: full-scale sample on ch0
    push(4095, 0);
    wait_cd("t2_convdone");
    chk("t2_latency", cyc - cap_cyc, 13);
    chk("t2_chvalid", chvalid, 4'b0001);
    chk("t2_convch", convch, 0);
    @(negedge genclk); #1;
    for (int k = 0; k < NDIG; k++) chk("t2_model_digit", mbank[0][k], e2[k]);
    for (int k = NDIG - 1; k >= 0; k--) begin
      got = 0;
      for (int i = 0; i < 40 && !got; i++) begin
        tick();
        if (chsel == 0 && digitmux == DSEL_W'(k)) got = 1;
      end
      chk("t2_dut_digit", got ? data : 4'hf, e2[k]);
    end

    // 3: new mask, two valid channels and one discarded tag
    enable = 1'b0;
    push(10, 0);
    wait_cd("t3_park");
    repeat (3) tick();
    chmask = 4'b0110; enable = 1'b1;
    wait_cf_fall("t3_conf");
    chk("t3_adcconf", adcconf, 8'h60);
    cd0 = dut_cd;
    push(123, 1); push(7, 2); push(55, 3);
    repeat (120) tick();
    chk("t3_convdone_count", dut_cd - cd0, 2);
    chk("t3_model_b1_d0", mbank[1][0], 3); chk("t3_model_b1_d1", mbank[1][1], 2);
    chk("t3_model_b1_d2", mbank[1][2], 1); chk("t3_model_b1_d3", mbank[1][3], 0);
    chk("t3_model_b2_d0", mbank[2][0], 7); chk("t3_model_b2_d1", mbank[2][1], 0);
    chk("t3_chvalid", chvalid, 4'b0111);

    // 4: reset while an acquire request is pending
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin tick(); if (adcdav) got = 1; end
    chk("t4_adcdav_high", got, 1);
    reset = 1'b1;
    tick();
    chk("t4_adcdav_drop", adcdav, 0); chk("t4_chvalid", chvalid, 0); chk("t4_adccf", adccf, 0);
    reset = 1'b0;
    tick();
    chk("t4_adccf_reassert", adccf, 1);
    wait_cf_fall("t4_conf");

    // 5: mask change during conversion, then disable
    push(999, 1);
    for (int i = 0; i < 40 && fq.size() > 0; i++) tick();
    repeat (3) tick();
    chmask = 4'b0011;
    wait_cd("t5_convdone");
    got = 0;
    for (int i = 0; i < 4 && !got; i++) begin tick(); if (adccf) got = 1; end
    chk("t5_reconf", got, 1);
    enable = 1'b0;
    wait_cf_fall("t5_conf_done");
    chk("t5_adcconf", adcconf, 8'h30);
    bad = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (adccf || adcdav) bad++; end
    chk("t5_idle_quiet", bad, 0);

`ifdef ADCAVG_EN
    // 6: four-sample average
    enable = 1'b1;
    cd0 = dut_cd;
    fq.push_back('{100, 0}); fq.push_back('{101, 0});
    fq.push_back('{102, 0}); fq.push_back('{104, 0});
    repeat (80) tick();
    chk("t6_convdone_count", dut_cd - cd0, 1);
    chk("t6_model_d0", mbank[0][0], 1); chk("t6_model_d1", mbank[0][1], 0);
    chk("t6_model_d2", mbank[0][2], 1); chk("t6_model_d3", mbank[0][3], 0);
`endif

    // Randomised scan with occasional mask and enable changes
    enable = 1'b1; rand_mode = 1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if ($urandom_range(0, 199) == 0) chmask = NCH'($urandom_range(1, 15));
      if ($urandom_range(0, 149) == 0) enable = ~enable;
    end
    rand_mode = 0; enable = 1'b0;
    repeat (40) tick();
    chk("drain", evq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
